// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned INSTR_W       = 32;
  localparam int unsigned PC_W          = 32;
  localparam int unsigned PC_STEP       = 4;
  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam int unsigned ENTRY_W       = PC_W + INSTR_W;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1,
    BUBBLE = 2'd2
  } fetch_state_e;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {pc, instr} buffer with synchronous flush and wrapping pointers.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_rdata,
  output logic [CW-1:0]      o_count,
  output logic               o_empty,
  output logic               o_full
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Storage needs no reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: issues word fetches, buffers {pc, instr}, handles redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = DEFAULT_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [PC_W-1:0]    r_fetch_pc;
  logic               w_req;
  logic               w_xfer;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_count_nxt;
  logic [ENTRY_W-1:0] w_head;
  logic [PC_W-1:0]    w_head_pc;

  // Reset gates the request combinationally so outputs drop the instant it asserts.
  assign w_req     = reset && (r_state == FETCH) && !w_full;
  assign imem_req  = w_req;
  assign imem_addr = reset ? r_fetch_pc : '0;

  assign w_xfer    = w_req && imem_ack && !redirect;
  assign out_valid = !w_empty && !redirect;
  assign w_pop     = out_valid && out_ready;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_flush(redirect),
    .i_push (w_xfer),
    .i_wdata({r_fetch_pc, imem_data}),
    .i_pop  (w_pop),
    .o_rdata(w_head),
    .o_count(w_count),
    .o_empty(w_empty),
    .o_full (w_full)
  );

  always_comb begin
    w_count_nxt = w_count;
    if (w_xfer && !w_pop)      w_count_nxt = w_count + CW'(1);
    else if (w_pop && !w_xfer) w_count_nxt = w_count - CW'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = BUBBLE;
    end else begin
      case (r_state)
        FETCH:   if (w_count_nxt == CW'(DEPTH)) w_state_nxt = FULL;
        FULL:    if (w_count_nxt != CW'(DEPTH)) w_state_nxt = FETCH;
        BUBBLE:  w_state_nxt = FETCH;
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= FETCH;
      r_fetch_pc <= align_pc(RESET_PC);
    end else begin
      r_state <= w_state_nxt;
      if (redirect)    r_fetch_pc <= align_pc(redirect_pc);
      else if (w_xfer) r_fetch_pc <= r_fetch_pc + PC_W'(PC_STEP);
    end
  end

  assign w_head_pc = w_head[ENTRY_W-1:INSTR_W];
  assign out_instr = out_valid ? w_head[INSTR_W-1:0] : '0;
  assign out_pc    = out_valid ? w_head_pc : '0;
  assign out_pc4   = out_valid ? (w_head_pc + PC_W'(PC_STEP)) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, queue-model random run, corner sequences.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic        imem_req,  imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic        out_valid, out_valid2;
  logic [31:0] out_instr, out_instr2;
  logic [31:0] out_pc,    out_pc2;
  logic [31:0] out_pc4,   out_pc42;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4)
  );

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .imem_data(imem_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_pc(out_pc2), .out_pc4(out_pc42)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f_tag(input logic [31:0] a);
    return 32'hD0DA_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b0; out_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; imem_data = '0;
    #1;
    chk("rst req",   32'(imem_req), 32'd0);
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst addr",  imem_addr, 32'd0);
    chk("rst pc",    out_pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    bit          ack;
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit rst, bit ack, bit rdy, bit redir, logic [31:0] rpc,
                              bit e_req, logic [31:0] e_addr, bit e_valid, logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    vt.push_back(v);
  endfunction

  logic [63:0] mq[$];
  logic [31:0] m_pc;
  bit          m_bub;
  bit          exp_req, exp_v;
  logic [63:0] head;

  initial begin
    reset = 1'b0; imem_ack = 1'b0; out_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; imem_data = '0;

    // Streaming from reset: addresses 0,4,8,... and head pc trailing by one cycle.
    add(1,1,1,0,0, 1,32'h00,0,0);
    add(0,1,1,0,0, 1,32'h04,1,32'h00);
    add(0,1,1,0,0, 1,32'h08,1,32'h04);
    add(0,1,1,0,0, 1,32'h0C,1,32'h08);
    // Decode stalled: four transfers fill the buffer, then one pop allows exactly one refetch.
    add(1,1,0,0,0, 1,32'h00,0,0);
    add(0,1,0,0,0, 1,32'h04,1,32'h00);
    add(0,1,0,0,0, 1,32'h08,1,32'h00);
    add(0,1,0,0,0, 1,32'h0C,1,32'h00);
    add(0,1,0,0,0, 0,32'h00,1,32'h00);
    add(0,1,1,0,0, 0,32'h00,1,32'h00);
    add(0,1,0,0,0, 1,32'h10,1,32'h04);
    add(0,1,0,0,0, 0,32'h00,1,32'h04);
    add(0,0,1,0,0, 0,32'h00,1,32'h04);
    add(0,0,0,0,0, 1,32'h14,1,32'h08);
    add(0,0,0,0,0, 1,32'h14,1,32'h08);
    // Redirect with 3 buffered and a transfer pending, then a redirect while in the bubble.
    add(1,1,0,0,0, 1,32'h00,0,0);
    add(0,1,0,0,0, 1,32'h04,1,32'h00);
    add(0,1,0,0,0, 1,32'h08,1,32'h00);
    add(0,1,1,1,32'h103, 1,32'h0C,0,0);
    add(0,1,1,0,0, 0,32'h00,0,0);
    add(0,1,1,0,0, 1,32'h100,0,0);
    add(0,1,1,0,0, 1,32'h104,1,32'h100);
    add(0,1,1,1,32'h202, 1,32'h108,0,0);
    add(0,1,1,1,32'h3FF, 0,32'h00,0,0);
    add(0,1,1,0,0, 0,32'h00,0,0);
    add(0,1,1,0,0, 1,32'h3FC,0,0);
    add(0,1,1,0,0, 1,32'h400,1,32'h3FC);

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      else @(negedge clk);
      imem_ack = vt[i].ack; out_ready = vt[i].rdy; redirect = vt[i].redir;
      redirect_pc = vt[i].rpc; imem_data = f_tag(vt[i].e_addr);
      #1;
      chk($sformatf("vec%0d req", i), 32'(imem_req), 32'(vt[i].e_req));
      if (vt[i].e_req) chk($sformatf("vec%0d addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d pc", i), out_pc, vt[i].e_valid ? vt[i].e_pc : 32'd0);
      chk($sformatf("vec%0d instr", i), out_instr, vt[i].e_valid ? f_tag(vt[i].e_pc) : 32'd0);
      chk($sformatf("vec%0d pc4", i), out_pc4, vt[i].e_valid ? vt[i].e_pc + 32'd4 : 32'd0);
    end

    // Random handshakes and rare redirects against an in-order queue model.
    do_reset();
    mq.delete(); m_pc = 32'h0; m_bub = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (c != 0) @(negedge clk);
      imem_ack    = ($urandom_range(0, 9) < 6);
      out_ready   = ($urandom_range(0, 9) < 6);
      redirect    = ($urandom_range(0, 63) == 0);
      redirect_pc = $urandom;
      imem_data   = $urandom;
      #1;
      exp_req = !m_bub && (mq.size() < DEPTH);
      exp_v   = (mq.size() != 0) && !redirect;
      head    = exp_v ? mq[0] : 64'd0;
      chk($sformatf("rnd%0d req", c), 32'(imem_req), 32'(exp_req));
      if (exp_req) chk($sformatf("rnd%0d addr", c), imem_addr, m_pc);
      chk($sformatf("rnd%0d valid", c), 32'(out_valid), 32'(exp_v));
      chk($sformatf("rnd%0d pc", c), out_pc, head[63:32]);
      chk($sformatf("rnd%0d instr", c), out_instr, head[31:0]);
      chk($sformatf("rnd%0d pc4", c), out_pc4, exp_v ? head[63:32] + 32'd4 : 32'd0);
      if (redirect) begin
        mq.delete();
        m_pc  = redirect_pc & ~32'h3;
        m_bub = 1'b1;
      end else begin
        if (exp_v && out_ready) void'(mq.pop_front());
        if (exp_req && imem_ack) begin
          mq.push_back({m_pc, imem_data});
          m_pc = m_pc + 32'd4;
        end
        m_bub = 1'b0;
      end
    end

    // Fetch address wraps past the top of the address space.
    do_reset();
    imem_ack = 1'b1; out_ready = 1'b1; imem_data = f_tag(32'hFFFF_FFF8);
    #1;
    chk("wrap req0",   32'(imem_req2), 32'd1);
    chk("wrap addr0",  imem_addr2, 32'hFFFF_FFF8);
    chk("wrap valid0", 32'(out_valid2), 32'd0);
    @(negedge clk);
    imem_data = f_tag(32'hFFFF_FFFC);
    #1;
    chk("wrap addr1",  imem_addr2, 32'hFFFF_FFFC);
    chk("wrap pc1",    out_pc2, 32'hFFFF_FFF8);
    chk("wrap pc4_1",  out_pc42, 32'hFFFF_FFFC);
    chk("wrap instr1", out_instr2, f_tag(32'hFFFF_FFF8));
    @(negedge clk);
    #1;
    chk("wrap addr2",  imem_addr2, 32'h0000_0000);
    chk("wrap pc2",    out_pc2, 32'hFFFF_FFFC);
    chk("wrap pc4_2",  out_pc42, 32'h0000_0000);

    // Asynchronous reset pulse mid-cycle with the buffer full.
    do_reset();
    imem_ack = 1'b1; out_ready = 1'b0; imem_data = f_tag(32'h0);
    repeat (5) @(negedge clk);
    #1;
    chk("full valid", 32'(out_valid), 32'd1);
    chk("full req",   32'(imem_req), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst req",   32'(imem_req), 32'd0);
    chk("arst addr",  imem_addr, 32'd0);
    chk("arst valid", 32'(out_valid), 32'd0);
    chk("arst instr", out_instr, 32'd0);
    chk("arst pc",    out_pc, 32'd0);
    chk("arst pc4",   out_pc4, 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rel req",   32'(imem_req), 32'd1);
    chk("rel addr",  imem_addr, 32'd0);
    chk("rel valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rel1 valid", 32'(out_valid), 32'd1);
    chk("rel1 pc",    out_pc, 32'd0);
    chk("rel1 addr",  imem_addr, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
